// File: rtl/hs_bus_amba_axilite_pkg.sv
// hs_bus_amba_axilite_pkg: bridge FSM encoding and AXI-Lite response codes
package hs_bus_amba_axilite_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_RESP = 3'd2,
    RD_ACC  = 3'd3,
    RD_RESP = 3'd4
  } axil_bridge_state_e;
  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  function automatic logic [1:0] axil_resp(input logic err);
    return err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  endfunction
endpackage

// File: rtl/hs_bus_amba_axilite_aw_w_join.sv
// hs_bus_amba_axilite_aw_w_join: captures AW and W independently and presents the joined write,
// forwarding same-cycle handshakes so a write can start the cycle its last half arrives
module hs_bus_amba_axilite_aw_w_join #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  awvalid_i,
  input  logic [ID_WIDTH-1:0]   awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [2:0]            awprot_i,
  input  logic                  awtrace_i,
  input  logic                  awidunq_i,
  input  logic                  wvalid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wtrace_i,
  output logic                  awready_o,
  output logic                  wready_o,
  output logic                  aw_cap_o,
  output logic                  w_cap_o,
  output logic                  full_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [2:0]            prot_o,
  output logic                  idunq_o,
  output logic                  trace_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [STRB_WIDTH-1:0] strb_o
);
  logic aw_q, aw_d, w_q, w_d, aw_hs, w_hs;
  logic awtrace_q, idunq_q, wtrace_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  assign awready_o = en_i & ~aw_q;
  assign wready_o  = en_i & ~w_q;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign aw_cap_o  = aw_q;
  assign w_cap_o   = w_q;
  assign full_o    = (aw_q | aw_hs) & (w_q | w_hs);
  assign aw_d      = ~clr_i & (aw_q | aw_hs);
  assign w_d       = ~clr_i & (w_q | w_hs);
  assign id_o      = aw_q ? id_q : awid_i;
  assign addr_o    = aw_q ? addr_q : awaddr_i;
  assign prot_o    = aw_q ? prot_q : awprot_i;
  assign idunq_o   = aw_q ? idunq_q : awidunq_i;
  assign data_o    = w_q ? data_q : wdata_i;
  assign strb_o    = w_q ? strb_q : wstrb_i;
  assign trace_o   = (aw_q ? awtrace_q : awtrace_i) | (w_q ? wtrace_q : wtrace_i);
  // capture flags and held channel payloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
      awtrace_q <= 1'b0;
      idunq_q   <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
      wtrace_q  <= 1'b0;
    end else begin
      aw_q <= aw_d;
      w_q  <= w_d;
      if (aw_hs) begin
        id_q      <= awid_i;
        addr_q    <= awaddr_i;
        prot_q    <= awprot_i;
        awtrace_q <= awtrace_i;
        idunq_q   <= awidunq_i;
      end
      if (w_hs) begin
        data_q   <= wdata_i;
        strb_q   <= wstrb_i;
        wtrace_q <= wtrace_i;
      end
    end
  end
endmodule

// File: rtl/hs_bus_amba_axilite_reg_bridge.sv
// hs_bus_amba_axilite_reg_bridge: AXI5-Lite slave terminating into a register strobe port;
// define HS_AXILITE_REG_BRIDGE_WAIT_EN to add reg_ready wait-states on register accesses
module hs_bus_amba_axilite_reg_bridge #(
  parameter int ID_W_WIDTH = 1,
  parameter int ID_R_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [ID_W_WIDTH-1:0] s_axilite_awid,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic [2:0]            s_axilite_awprot,
  input  logic                  s_axilite_awtrace,
  input  logic                  s_axilite_awidunq,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  input  logic [DATA_WIDTH-1:0] s_axilite_wdata,
  input  logic [STRB_WIDTH-1:0] s_axilite_wstrb,
  input  logic                  s_axilite_wtrace,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  output logic [ID_W_WIDTH-1:0] s_axilite_bid,
  output logic                  s_axilite_bidunq,
  output logic                  s_axilite_btrace,
  output logic [1:0]            s_axilite_bresp,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  input  logic [ID_R_WIDTH-1:0] s_axilite_arid,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic [2:0]            s_axilite_arprot,
  input  logic                  s_axilite_artrace,
  input  logic                  s_axilite_aridunq,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready,
  output logic [ID_R_WIDTH-1:0] s_axilite_rid,
  output logic                  s_axilite_ridunq,
  output logic                  s_axilite_rtrace,
  output logic [DATA_WIDTH-1:0] s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  reg_wen,
  output logic                  reg_ren,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [2:0]            reg_prot,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_WIDTH-1:0] reg_wstrb,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
`ifdef HS_AXILITE_REG_BRIDGE_WAIT_EN
  input  logic                  reg_ready,
`endif
  input  logic                  reg_err
);
  import hs_bus_amba_axilite_pkg::*;
  axil_bridge_state_e state_q, state_d;
  logic up_q, last_wr_q, idle, acc_done, acc_d, wr_gnt, rd_gnt, wr_done, rd_done;
  logic aw_cap, w_cap, wr_full, j_idunq, j_trace;
  logic [ID_W_WIDTH-1:0] j_id;
  logic [ADDR_WIDTH-1:0] j_addr;
  logic [2:0]            j_prot;
  logic [DATA_WIDTH-1:0] j_data;
  logic [STRB_WIDTH-1:0] j_strb;
`ifdef HS_AXILITE_REG_BRIDGE_WAIT_EN
  assign acc_done = reg_ready;
`else
  assign acc_done = 1'b1;
`endif
  // up_q keeps every ready low until the first clock after reset release
  assign idle              = up_q & (state_q == IDLE);
  assign s_axilite_arready = idle & ~aw_cap & ~w_cap & (~wr_full | last_wr_q);
  assign rd_gnt            = s_axilite_arvalid & s_axilite_arready;
  assign wr_gnt            = idle & wr_full & ~rd_gnt;
  assign acc_d             = (state_d == WR_ACC) | (state_d == RD_ACC);
  assign wr_done           = (state_q == WR_ACC) & acc_done;
  assign rd_done           = (state_q == RD_ACC) & acc_done;
  hs_bus_amba_axilite_aw_w_join #(
    .ID_WIDTH(ID_W_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)
  ) u_join (
    .clk(clk), .rst_n(rst_n), .en_i(idle), .clr_i(wr_gnt),
    .awvalid_i(s_axilite_awvalid), .awid_i(s_axilite_awid), .awaddr_i(s_axilite_awaddr),
    .awprot_i(s_axilite_awprot), .awtrace_i(s_axilite_awtrace), .awidunq_i(s_axilite_awidunq),
    .wvalid_i(s_axilite_wvalid), .wdata_i(s_axilite_wdata), .wstrb_i(s_axilite_wstrb),
    .wtrace_i(s_axilite_wtrace), .awready_o(s_axilite_awready), .wready_o(s_axilite_wready),
    .aw_cap_o(aw_cap), .w_cap_o(w_cap), .full_o(wr_full), .id_o(j_id), .addr_o(j_addr),
    .prot_o(j_prot), .idunq_o(j_idunq), .trace_o(j_trace), .data_o(j_data), .strb_o(j_strb)
  );
  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wr_gnt ? WR_ACC : rd_gnt ? RD_ACC : IDLE;
      WR_ACC:  state_d = acc_done ? WR_RESP : WR_ACC;
      WR_RESP: state_d = s_axilite_bready ? IDLE : WR_RESP;
      RD_ACC:  state_d = acc_done ? RD_RESP : RD_ACC;
      RD_RESP: state_d = s_axilite_rready ? IDLE : RD_RESP;
      default: state_d = IDLE;
    endcase
  end
  // FSM, arbitration flag and registered register-port operands (zero outside an access)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      up_q      <= 1'b0;
      last_wr_q <= 1'b0;
      reg_wen   <= 1'b0;
      reg_ren   <= 1'b0;
      reg_addr  <= '0;
      reg_prot  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      up_q      <= 1'b1;
      last_wr_q <= wr_gnt ? 1'b1 : rd_gnt ? 1'b0 : last_wr_q;
      reg_wen   <= state_d == WR_ACC;
      reg_ren   <= state_d == RD_ACC;
      reg_addr  <= wr_gnt ? j_addr : rd_gnt ? s_axilite_araddr : acc_d ? reg_addr : '0;
      reg_prot  <= wr_gnt ? j_prot : rd_gnt ? s_axilite_arprot : acc_d ? reg_prot : '0;
      reg_wdata <= wr_gnt ? j_data : (state_d == WR_ACC) ? reg_wdata : '0;
      reg_wstrb <= wr_gnt ? j_strb : (state_d == WR_ACC) ? reg_wstrb : '0;
    end
  end
  // B/R channels: echoes latched at grant, response latched when the access completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axilite_bvalid <= 1'b0;
      s_axilite_bid    <= '0;
      s_axilite_bidunq <= 1'b0;
      s_axilite_btrace <= 1'b0;
      s_axilite_bresp  <= AXIL_RESP_OKAY;
      s_axilite_rvalid <= 1'b0;
      s_axilite_rid    <= '0;
      s_axilite_ridunq <= 1'b0;
      s_axilite_rtrace <= 1'b0;
      s_axilite_rdata  <= '0;
      s_axilite_rresp  <= AXIL_RESP_OKAY;
    end else begin
      s_axilite_bvalid <= wr_done | (s_axilite_bvalid & ~s_axilite_bready);
      s_axilite_rvalid <= rd_done | (s_axilite_rvalid & ~s_axilite_rready);
      if (wr_gnt) begin
        s_axilite_bid    <= j_id;
        s_axilite_bidunq <= j_idunq;
        s_axilite_btrace <= j_trace;
      end
      if (rd_gnt) begin
        s_axilite_rid    <= s_axilite_arid;
        s_axilite_ridunq <= s_axilite_aridunq;
        s_axilite_rtrace <= s_axilite_artrace;
      end
      if (wr_done) s_axilite_bresp <= axil_resp(reg_err);
      if (rd_done) begin
        s_axilite_rresp <= axil_resp(reg_err);
        s_axilite_rdata <= reg_err ? '0 : reg_rdata;
      end
    end
  end
endmodule

// File: tb/tb_hs_bus_amba_axilite_reg_bridge.sv
// tb_hs_bus_amba_axilite_reg_bridge: scoreboard bench for the AXI-Lite register bridge
module tb_hs_bus_amba_axilite_reg_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic awvalid = 0, awready, awid = 0, awtrace = 0, awidunq = 0;
  logic [31:0] awaddr = 0;
  logic [2:0] awprot = 0;
  logic wvalid = 0, wready, wtrace = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic bvalid, bready = 1, bid, bidunq, btrace;
  logic [1:0] bresp;
  logic arvalid = 0, arready, arid = 0, artrace = 0, aridunq = 0;
  logic [31:0] araddr = 0;
  logic [2:0] arprot = 0;
  logic rvalid, rready = 1, rid, ridunq, rtrace;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic reg_wen, reg_ren, reg_err = 0, reg_ready = 1;
  logic [31:0] reg_addr, reg_wdata, reg_rdata = 0;
  logic [2:0] reg_prot;
  logic [3:0] reg_wstrb;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic wr; logic [31:0] addr; logic [2:0] prot; logic [31:0] data; logic [3:0] strb;} reg_t;
  typedef struct {logic id; logic idunq; logic trace; logic [31:0] data; logic [1:0] resp;} rsp_t;
  reg_t exp_reg[$];
  rsp_t exp_b[$], exp_r[$];
  reg_t er;
  rsp_t ep;

  hs_bus_amba_axilite_reg_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_axilite_awvalid(awvalid), .s_axilite_awready(awready), .s_axilite_awid(awid),
    .s_axilite_awaddr(awaddr), .s_axilite_awprot(awprot), .s_axilite_awtrace(awtrace),
    .s_axilite_awidunq(awidunq), .s_axilite_wvalid(wvalid), .s_axilite_wready(wready),
    .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wtrace(wtrace),
    .s_axilite_bvalid(bvalid), .s_axilite_bready(bready), .s_axilite_bid(bid),
    .s_axilite_bidunq(bidunq), .s_axilite_btrace(btrace), .s_axilite_bresp(bresp),
    .s_axilite_arvalid(arvalid), .s_axilite_arready(arready), .s_axilite_arid(arid),
    .s_axilite_araddr(araddr), .s_axilite_arprot(arprot), .s_axilite_artrace(artrace),
    .s_axilite_aridunq(aridunq), .s_axilite_rvalid(rvalid), .s_axilite_rready(rready),
    .s_axilite_rid(rid), .s_axilite_ridunq(ridunq), .s_axilite_rtrace(rtrace),
    .s_axilite_rdata(rdata), .s_axilite_rresp(rresp),
    .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr), .reg_prot(reg_prot),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
`ifdef HS_AXILITE_REG_BRIDGE_WAIT_EN
    .reg_ready(reg_ready),
`endif
    .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop and compare whenever the DUT produces a register access or a response
  always @(negedge clk) begin
    if (rst_n) begin
      if ((reg_wen || reg_ren) && reg_ready) begin
        if (exp_reg.size() == 0) chk("reg_unexpected", 1, 0);
        else begin
          er = exp_reg.pop_front();
          chk("reg_wen", reg_wen, er.wr);
          chk("reg_ren", reg_ren, !er.wr);
          chk("reg_addr", reg_addr, er.addr);
          chk("reg_prot", reg_prot, er.prot);
          chk("reg_wdata", reg_wdata, er.wr ? er.data : 32'h0);
          chk("reg_wstrb", reg_wstrb, er.wr ? er.strb : 4'h0);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          ep = exp_b.pop_front();
          chk("bid", bid, ep.id);
          chk("bidunq", bidunq, ep.idunq);
          chk("btrace", btrace, ep.trace);
          chk("bresp", bresp, ep.resp);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          ep = exp_r.pop_front();
          chk("rid", rid, ep.id);
          chk("ridunq", ridunq, ep.idunq);
          chk("rtrace", rtrace, ep.trace);
          chk("rdata", rdata, ep.data);
          chk("rresp", rresp, ep.resp);
        end
      end
    end
  end

  task automatic set_wr(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d, input logic [3:0] s,
                        input logic id, input logic u, input logic at, input logic wt, input logic e,
                        input logic do_aw, input logic do_w);
    awaddr = a; awprot = p; awid = id; awidunq = u; awtrace = at;
    wdata = d; wstrb = s; wtrace = wt; reg_err = e;
    awvalid = do_aw; wvalid = do_w;
    exp_reg.push_back('{1'b1, a, p, d, s});
    exp_b.push_back('{id, u, at | wt, 32'h0, e ? 2'b10 : 2'b00});
  endtask

  task automatic set_rd(input logic [31:0] a, input logic [2:0] p, input logic id, input logic u,
                        input logic t, input logic [31:0] d, input logic e);
    araddr = a; arprot = p; arid = id; aridunq = u; artrace = t;
    reg_rdata = d; reg_err = e; arvalid = 1'b1;
    exp_reg.push_back('{1'b0, a, p, 32'h0, 4'h0});
    exp_r.push_back('{id, u, t, e ? 32'h0 : d, e ? 2'b10 : 2'b00});
  endtask

  // hold each valid until its handshake completes; returns at posedge+1 after the last one
  task automatic hs();
    logic a, w, r;
    for (int i = 0; i < 20 && (awvalid || wvalid || arvalid); i++) begin
      @(negedge clk);
      a = awvalid & awready; w = wvalid & wready; r = arvalid & arready;
      @(posedge clk); #1;
      if (a) awvalid = 0;
      if (w) wvalid = 0;
      if (r) arvalid = 0;
    end
    if (awvalid || wvalid || arvalid) begin
      chk("hs_timeout", {awvalid, wvalid, arvalid}, 0);
      awvalid = 0; wvalid = 0; arvalid = 0;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 30 && (bvalid || rvalid || reg_wen || reg_ren); i++) begin
      @(posedge clk); #1;
    end
    chk("settle_idle", {bvalid, rvalid, reg_wen, reg_ren}, 0);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst_n = 1;
    chk("ready_before_edge", {awready, wready, arready}, 0);
    @(posedge clk); #1;
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ready"}, {awready, wready, arready}, 0);
    chk({tag, "_valid"}, {bvalid, rvalid, reg_wen, reg_ren}, 0);
    chk({tag, "_b"}, {bid, bidunq, btrace, bresp}, 0);
    chk({tag, "_reg"}, {reg_addr, reg_wdata}, 0);
    exp_reg.delete(); exp_b.delete(); exp_r.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid, reg_wen, reg_ren}, 0);
    repeat (2) @(posedge clk);
    release_rst();
    // same-cycle AW+W: reg_wen in cycle 1, bvalid in cycle 2
    set_wr(32'h10, 3'b010, 32'hA5A5A5A5, 4'hF, 1, 1, 1, 0, 0, 1, 1);
    hs();
    chk("w1_wen_c1", reg_wen, 1);
    chk("w1_bvalid_c1", bvalid, 0);
    @(posedge clk); #1;
    chk("w1_bvalid_c2", bvalid, 1);
    settle();
    // W two cycles ahead of AW
    set_wr(32'h44, 3'b001, 32'h0BADF00D, 4'h5, 0, 0, 0, 1, 0, 0, 1);
    hs();
    chk("wfirst_arready", arready, 0);
    chk("wfirst_readies", {awready, wready}, 2'b10);
    @(posedge clk); #1;
    chk("wfirst_arready2", arready, 0);
    awvalid = 1;
    hs();
    chk("wfirst_wen", reg_wen, 1);
    settle();
    // write with register error
    set_wr(32'h48, 3'b000, 32'h11112222, 4'h3, 1, 0, 0, 0, 1, 1, 1);
    hs();
    settle();
    // read 0x20: reg_ren in cycle 1, rvalid in cycle 2
    set_rd(32'h20, 3'b100, 1, 1, 1, 32'h12345678, 0);
    hs();
    chk("r1_ren_c1", reg_ren, 1);
    @(posedge clk); #1;
    chk("r1_rvalid_c2", rvalid, 1);
    settle();
    // read with register error
    set_rd(32'h24, 3'b000, 0, 0, 0, 32'hDEADBEEF, 1);
    hs();
    settle();
    // two contentions in a row, write served first each time
    for (int k = 0; k < 2; k++) begin
      rready = (k == 1);
      set_wr(32'h100 + k, 3'b011, 32'h5A5A0000 + k, 4'hC, k[0], 1, 0, 1, 0, 1, 1);
      set_rd(32'h200 + k, 3'b110, !k[0], 0, 1, 32'hCAFE0000 + k, 0);
      hs();
      for (int i = 0; i < 10 && !rvalid; i++) begin
        @(posedge clk); #1;
      end
      if (k == 0) begin
        repeat (5) begin
          chk("r_hold_valid", rvalid, 1);
          chk("r_hold_data", rdata, 32'hCAFE0000);
          chk("r_hold_id", rid, 1);
          @(posedge clk); #1;
        end
        rready = 1;
      end
      settle();
    end
`ifdef HS_AXILITE_REG_BRIDGE_WAIT_EN
    // wait-states: reg_ready low 3 cycles holds reg_wen 4 cycles
    reg_ready = 0;
    set_wr(32'h300, 3'b000, 32'h77778888, 4'hF, 0, 0, 0, 0, 0, 1, 1);
    hs();
    for (int i = 0; i < 3; i++) begin
      chk("wait_wen_held", reg_wen, 1);
      chk("wait_addr_held", reg_addr, 32'h300);
      @(posedge clk); #1;
    end
    reg_ready = 1;
    chk("wait_wen_last", reg_wen, 1);
    @(posedge clk); #1;
    chk("wait_wen_done", reg_wen, 0);
    chk("wait_bvalid", bvalid, 1);
    settle();
    // reset during a stalled access
    reg_ready = 0;
    set_wr(32'h304, 3'b000, 32'h99990000, 4'hF, 1, 1, 1, 0, 0, 1, 1);
    hs();
    chk("wait2_wen", reg_wen, 1);
    rst_n = 0;
    #1;
    zero_chk("rst_acc");
    reg_ready = 1;
    release_rst();
`endif
    // reset while a B response is pending
    bready = 0;
    set_wr(32'h400, 3'b111, 32'hFFFF0000, 4'hF, 1, 1, 1, 1, 1, 1, 1);
    hs();
    @(posedge clk); #1;
    chk("rst_pre_b", {bvalid, bid, btrace, bresp}, 5'b11110);
    rst_n = 0;
    #1;
    zero_chk("rst_resp");
    bready = 1;
    reg_err = 0;
    release_rst();
    chk("queues_empty", exp_reg.size() + exp_b.size() + exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
